// File: rtl/evm_pkg.sv
// evm_pkg: ballot FSM states, candidate type and candidate count shared by the EVM front end
package evm_pkg;
  localparam int NUM_CANDIDATES = 4;
  typedef enum logic [1:0] {LOCKED, ARMED, CAST, WAIT_REL} ballot_state_t;
  typedef logic [$clog2(NUM_CANDIDATES)-1:0] candidate_t;
endpackage

// File: rtl/ballot_controller_if.sv
// ballot_controller_if: raw voter/officer inputs and conditioned vote outputs of the ballot front end
//   master: drives ballot_release, vote_btn, candidate_sw; observes the vote/status outputs
//   slave : the controller side
interface ballot_controller_if #(parameter int TOTAL_W = 8);
  import evm_pkg::*;
  logic ballot_release;
  logic vote_btn;
  candidate_t candidate_sw;
  logic vote_valid;
  candidate_t vote_candidate;
  logic armed;
  logic vote_rejected;
  logic arm_expired;
  logic [TOTAL_W-1:0] total_cast;
  modport master(
    output ballot_release, vote_btn, candidate_sw,
    input vote_valid, vote_candidate, armed, vote_rejected, arm_expired, total_cast
  );
  modport slave(
    input ballot_release, vote_btn, candidate_sw,
    output vote_valid, vote_candidate, armed, vote_rejected, arm_expired, total_cast
  );
endinterface

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop sync, debounce and registered rise strobe for one raw button
//   clk, reset (async, active-high), raw_i: raw button; level_o: debounced level; rise_o: 1-cycle 0->1 strobe
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic s1_q, s2_q, db_q, db_d, rise_q, differ, done;
  logic [CW-1:0] cnt_q;
  assign differ = s2_q != db_q;
  // accept once the synchronised value has disagreed for DEBOUNCE_CYCLES consecutive cycles
  assign done = differ && (cnt_q == CW'(DEBOUNCE_CYCLES - 1));
  assign db_d = done ? s2_q : db_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      cnt_q <= '0;
      db_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      s1_q <= raw_i;
      s2_q <= s1_q;
      cnt_q <= (differ && !done) ? cnt_q + 1'b1 : '0;
      db_q <= db_d;
      rise_q <= db_d & ~db_q;
    end
  assign level_o = db_q;
  assign rise_o = rise_q;
endmodule

// File: rtl/ballot_controller.sv
// ballot_controller: one-vote-per-release EVM front end producing a clean vote strobe and candidate
//   clk, reset (async, active-high); bus: ballot_controller_if.slave (raw buttons/switches in, vote strobes/status out)
//   Optional BALLOT_TIMEOUT_EN: an armed ballot expires after TIMEOUT_CYCLES without a vote
module ballot_controller
  import evm_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int TIMEOUT_CYCLES = 1_000_000_000,
  parameter int TOTAL_W = 8
) (
  input logic clk,
  input logic reset,
  ballot_controller_if.slave bus
);
  ballot_state_t state_q;
  candidate_t cand_s1_q, cand_s2_q, cand_q;
  logic vote_level, vote_rise, rel_rise, unused_rel_level, tmo_hit;
  logic valid_q, rejected_q, armed_q, expired_q;
  logic [TOTAL_W-1:0] total_q;
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_vote (
    .clk(clk), .reset(reset), .raw_i(bus.vote_btn), .level_o(vote_level), .rise_o(vote_rise)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_rel (
    .clk(clk), .reset(reset), .raw_i(bus.ballot_release), .level_o(unused_rel_level), .rise_o(rel_rise)
  );
`ifdef BALLOT_TIMEOUT_EN
  logic [31:0] tmo_q;
  // held at 0 outside ARMED, so every entry into ARMED starts from 0
  always_ff @(posedge clk or posedge reset)
    if (reset) tmo_q <= '0;
    else tmo_q <= (state_q == ARMED) ? tmo_q + 1'b1 : '0;
  assign tmo_hit = tmo_q == 32'(TIMEOUT_CYCLES - 1);
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT_CYCLES);
  assign tmo_hit = 1'b0;
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= LOCKED;
      cand_s1_q <= '0;
      cand_s2_q <= '0;
      cand_q <= '0;
      valid_q <= 1'b0;
      rejected_q <= 1'b0;
      armed_q <= 1'b0;
      expired_q <= 1'b0;
      total_q <= '0;
    end else begin
      cand_s1_q <= bus.candidate_sw;
      cand_s2_q <= cand_s1_q;
      valid_q <= 1'b0;
      rejected_q <= 1'b0;
      expired_q <= 1'b0;
      armed_q <= 1'b0;
      case (state_q)
        // release outranks a simultaneous vote press: arm, drop the vote silently
        LOCKED:
          if (rel_rise) begin
            state_q <= ARMED;
            armed_q <= 1'b1;
          end else if (vote_rise) rejected_q <= 1'b1;
        // a vote in the expiry cycle wins over the timeout
        ARMED:
          if (vote_rise) begin
            state_q <= CAST;
            valid_q <= 1'b1;
            cand_q <= cand_s2_q;
            total_q <= &total_q ? total_q : total_q + 1'b1;
          end else if (tmo_hit) begin
            state_q <= LOCKED;
            expired_q <= 1'b1;
          end else armed_q <= 1'b1;
        CAST: state_q <= WAIT_REL;
        WAIT_REL: state_q <= vote_level ? WAIT_REL : LOCKED;
        default: state_q <= LOCKED;
      endcase
    end
  assign bus.vote_valid = valid_q;
  assign bus.vote_candidate = cand_q;
  assign bus.armed = armed_q;
  assign bus.vote_rejected = rejected_q;
  assign bus.arm_expired = expired_q;
  assign bus.total_cast = total_q;
endmodule

// File: tb/tb_ballot_controller.sv
// tb_ballot_controller: directed scenarios plus random button soup checked cycle by cycle against a reference model
module tb_ballot_controller;
  localparam int DEB = 4;
  localparam int TMO = 20;
  localparam int TW = 3;
  localparam int TMAX = (1 << TW) - 1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  ballot_controller_if #(.TOTAL_W(TW)) bus();
  ballot_controller #(.DEBOUNCE_CYCLES(DEB), .TIMEOUT_CYCLES(TMO), .TOTAL_W(TW)) dut (
    .clk(clk), .reset(rst), .bus(bus)
  );
  int n_vec = 0, n_err = 0, n_valid = 0, n_rej = 0, n_exp = 0;
  int b_v, b_r, b_e;
  bit found;
  // reference model: index 0 = vote button, 1 = release button
  bit m_s1[2], m_s2[2], m_db[2], m_rise[2];
  logic [DEB-1:0] m_hist[2];
  logic [1:0] m_c1, m_c2, m_cand;
  bit m_open, m_cast, m_wait, m_vv, m_vr, m_ae;
  int m_total, m_timer;

  task automatic check(string tag, int got, int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < 2; b++) begin
      m_s1[b] = 0; m_s2[b] = 0; m_db[b] = 0; m_rise[b] = 0; m_hist[b] = '0;
    end
    m_c1 = 0; m_c2 = 0; m_cand = 0;
    m_open = 0; m_cast = 0; m_wait = 0; m_vv = 0; m_vr = 0; m_ae = 0;
    m_total = 0; m_timer = 0;
  endtask

  task automatic model_step();
    bit raw[2];
    bit vr, rr, vl, nd;
    logic [1:0] c;
    if (rst) begin
      model_reset();
      return;
    end
    raw[0] = bus.vote_btn;
    raw[1] = bus.ballot_release;
    vr = m_rise[0]; rr = m_rise[1]; vl = m_db[0]; c = m_c2;
    for (int b = 0; b < 2; b++) begin
      // history of "synchronised value disagrees with accepted value"; DEB in a row flips it
      m_hist[b] = {m_hist[b][DEB-2:0], m_s2[b] != m_db[b]};
      nd = (&m_hist[b]) ? ~m_db[b] : m_db[b];
      if (nd != m_db[b]) m_hist[b] = '0;
      m_rise[b] = !m_db[b] && nd;
      m_db[b] = nd;
      m_s2[b] = m_s1[b];
      m_s1[b] = raw[b];
    end
    m_c2 = m_c1;
    m_c1 = bus.candidate_sw;
    m_vv = 0; m_vr = 0; m_ae = 0;
    if (m_cast) begin
      m_cast = 0;
      m_wait = 1;
    end else if (m_wait) m_wait = vl;
    else if (m_open) begin
      if (vr) begin
        m_open = 0; m_cast = 1; m_vv = 1; m_cand = c;
        m_total = (m_total < TMAX) ? m_total + 1 : TMAX;
      end
`ifdef BALLOT_TIMEOUT_EN
      else if (m_timer == TMO - 1) begin
        m_open = 0;
        m_ae = 1;
      end
`endif
      else m_timer++;
    end else if (rr) begin
      m_open = 1;
      m_timer = 0;
    end else if (vr) m_vr = 1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("vote_valid", bus.vote_valid, m_vv);
    check("vote_rejected", bus.vote_rejected, m_vr);
    check("arm_expired", bus.arm_expired, m_ae);
    check("armed", bus.armed, m_open);
    check("vote_candidate", bus.vote_candidate, m_cand);
    check("total_cast", bus.total_cast, m_total);
    if (bus.vote_valid) check("armed_at_cast", bus.armed, 0);
    if (bus.vote_valid && bus.vote_rejected) check("strobe_exclusive", 1, 0);
    n_valid += bus.vote_valid;
    n_rej += bus.vote_rejected;
    n_exp += bus.arm_expired;
  endtask

  task automatic hold(int n);
    repeat (n) tick();
  endtask

  task automatic arm();
    bus.ballot_release = 1'b1;
    hold(8);
    bus.ballot_release = 1'b0;
    hold(8);
  endtask

  task automatic cast_vote(logic [1:0] c);
    bus.candidate_sw = c;
    bus.vote_btn = 1'b1;
    hold(10);
    bus.vote_btn = 1'b0;
    hold(10);
  endtask

  initial begin
    bus.vote_btn = 1'b0;
    bus.ballot_release = 1'b0;
    bus.candidate_sw = 2'd0;
    model_reset();
    hold(3);
    rst = 1'b0;
    hold(2);
    // 1: vote with no ballot released
    b_v = n_valid; b_r = n_rej;
    bus.vote_btn = 1'b1;
    hold(10);
    bus.vote_btn = 1'b0;
    hold(10);
    check("t1_rejected", n_rej - b_r, 1);
    check("t1_valid", n_valid - b_v, 0);
    check("t1_total", bus.total_cast, 0);
    check("t1_armed", bus.armed, 0);
    // 2: release then a long press for candidate 2
    b_v = n_valid;
    bus.candidate_sw = 2'd2;
    arm();
    check("t2_armed", bus.armed, 1);
    cast_vote(2'd2);
    check("t2_valid", n_valid - b_v, 1);
    check("t2_cand", bus.vote_candidate, 2);
    check("t2_total", bus.total_cast, 1);
    // 3: bouncing press is ignored, a stable one votes
    arm();
    b_v = n_valid;
    for (int i = 0; i < 8; i++) begin
      bus.vote_btn = (i % 2) == 0;
      hold(2);
    end
    hold(6);
    check("t3_bounce_valid", n_valid - b_v, 0);
    check("t3_still_armed", bus.armed, 1);
    cast_vote(2'd1);
    check("t3_valid", n_valid - b_v, 1);
    check("t3_cand", bus.vote_candidate, 1);
    // 4: button held across arming must be re-pressed
    b_v = n_valid;
    bus.vote_btn = 1'b1;
    hold(10);
    arm();
    check("t4_armed", bus.armed, 1);
    check("t4_no_cast", n_valid - b_v, 0);
    bus.vote_btn = 1'b0;
    hold(10);
    check("t4_armed_after_release", bus.armed, 1);
    cast_vote(2'd3);
    check("t4_valid", n_valid - b_v, 1);
    check("t4_cand", bus.vote_candidate, 3);
    // 5: saturation, then reset during CAST
    b_v = n_valid;
    for (int i = 0; i < 8; i++) begin
      arm();
      cast_vote(2'($urandom_range(0, 3)));
    end
    check("t5_valid_count", n_valid - b_v, 8);
    check("t5_total_sat", bus.total_cast, TMAX);
    arm();
    bus.candidate_sw = 2'd1;
    bus.vote_btn = 1'b1;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      found = bus.vote_valid;
    end
    check("t5_cast_seen", found, 1);
    rst = 1'b1;
    #1;
    check("t5_rst_valid", bus.vote_valid, 0);
    check("t5_rst_armed", bus.armed, 0);
    check("t5_rst_total", bus.total_cast, 0);
    check("t5_rst_cand", bus.vote_candidate, 0);
    tick();
    rst = 1'b0;
    bus.vote_btn = 1'b0;
    hold(10);
    b_r = n_rej;
    bus.vote_btn = 1'b1;
    hold(10);
    bus.vote_btn = 1'b0;
    hold(10);
    check("t5_locked_rejects", n_rej - b_r, 1);
    // 6: armed ballot lifetime
    b_e = n_exp;
    b_r = n_rej;
    arm();
`ifdef BALLOT_TIMEOUT_EN
    hold(25);
    check("t6_expired", n_exp - b_e, 1);
    check("t6_armed", bus.armed, 0);
    bus.vote_btn = 1'b1;
    hold(10);
    bus.vote_btn = 1'b0;
    hold(10);
    check("t6_rejected", n_rej - b_r, 1);
`else
    hold(100);
    check("t6_armed", bus.armed, 1);
    check("t6_expired", n_exp - b_e, 0);
`endif
    // random button soup from a fresh reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 120; i++) begin
      bus.vote_btn = 1'($urandom_range(0, 1));
      bus.ballot_release = $urandom_range(0, 3) == 0;
      bus.candidate_sw = 2'($urandom_range(0, 3));
      hold($urandom_range(1, 9));
    end
    bus.vote_btn = 1'b0;
    bus.ballot_release = 1'b0;
    hold(12);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
